// File: rtl/mor1kx_dpram_pkg.sv
// Shared types and helpers for the multi-port single-clock RAM and its read ports.
package mor1kx_dpram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dpram_state_e;

  // Widest word the merge helper handles; callers zero-extend into it and truncate back.
  localparam int unsigned MERGE_MAX_W  = 512;
  localparam int unsigned MERGE_MAX_BE = MERGE_MAX_W / 8;

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic logic [MERGE_MAX_W-1:0] merge(
    input logic [MERGE_MAX_W-1:0]  old_w,
    input logic [MERGE_MAX_W-1:0]  new_w,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int b = 0; b < int'(MERGE_MAX_BE); b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mor1kx_dpram_rd_port.sv
// One read port: collision detect, write-to-read byte-merge bypass, optional
// output register and dvalid pipeline.
module mor1kx_dpram_rd_port
  import mor1kx_dpram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int BE_W          = 4,
  parameter int ENABLE_BYPASS = 1,
  parameter int OUT_REG       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [BE_W-1:0]       wbe_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dvalid_o
);

  logic                  hit;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  vld_q;

  assign hit    = (ENABLE_BYPASS != 0) && we_i && (waddr_i == raddr_i);
  assign merged = DATA_WIDTH'(merge(MERGE_MAX_W'(rdata_i), MERGE_MAX_W'(din_i),
                                    MERGE_MAX_BE'(wbe_i)));

  // Without a hit the array word is the pre-write value, giving read-first behaviour.
  always_comb begin
    rd_d = rdata_i;
    if (hit) rd_d = merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= re_i;
      if (re_i) rd_q <= rd_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q     <= '0;
        out_vld_q <= 1'b0;
      end else begin
        out_vld_q <= vld_q;
        if (vld_q) out_q <= rd_q;
      end
    end

    assign dout_o   = out_q;
    assign dvalid_o = out_vld_q;
  end else begin : g_noreg
    assign dout_o   = rd_q;
    assign dvalid_o = vld_q;
  end

endmodule

// File: rtl/mor1kx_multiport_dpram_sclk.sv
// Single-clock RAM with one byte-enabled write port, NUM_RD read ports and an
// optional post-reset clear sweep.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | zeroing mem[clr_cnt_q], one word per cycle; user traffic ignored
// ST_RUN  | normal operation; writes and reads accepted
module mor1kx_multiport_dpram_sclk
  import mor1kx_dpram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_RD         = 2,
  parameter int ENABLE_BYPASS  = 1,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [DATA_WIDTH/8-1:0]      wbe,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic [NUM_RD-1:0]            re,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] dout,
  output logic [NUM_RD-1:0]            dvalid,
  output logic                         init_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BE_W  = int'(be_width(DATA_WIDTH));

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > int'(MERGE_MAX_W)) begin : g_bad_width
    $error("mor1kx_multiport_dpram_sclk: DATA_WIDTH must be a multiple of 8 and <= MERGE_MAX_W");
  end
  if (NUM_RD < 1) begin : g_bad_num_rd
    $error("mor1kx_multiport_dpram_sclk: NUM_RD must be at least 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  dpram_state_e          state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  init_busy_q;
  logic                  run;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_word;

  assign run       = (state_q == ST_RUN);
  assign wr_en     = run && we;
  assign init_busy = init_busy_q;
  assign wr_word   = DATA_WIDTH'(merge(MERGE_MAX_W'(mem[waddr]), MERGE_MAX_W'(din),
                                       MERGE_MAX_BE'(wbe)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      clr_cnt_q   <= '0;
      init_busy_q <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        ST_INIT: begin
          if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q     <= ST_RUN;
            clr_cnt_q   <= '0;
            init_busy_q <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          init_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_RUN;
          init_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // The array itself is never reset; the clear sweep is the only way it is zeroed.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wr_word;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DATA_WIDTH-1:0] rd_word;

    assign rd_word = mem[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];

    mor1kx_dpram_rd_port #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .BE_W          (BE_W),
      .ENABLE_BYPASS (ENABLE_BYPASS),
      .OUT_REG       (OUT_REG)
    ) u_rd_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (wr_en),
      .wbe_i    (wbe),
      .waddr_i  (waddr),
      .din_i    (din),
      .re_i     (re[i] & run),
      .raddr_i  (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .rdata_i  (rd_word),
      .dout_o   (dout[i*DATA_WIDTH +: DATA_WIDTH]),
      .dvalid_o (dvalid[i])
    );
  end

endmodule

// File: tb/tb_mor1kx_multiport_dpram_sclk.sv
// Directed table, reset/clear sequences and a random reference-model run against
// two RAM instances: bypass on/no output reg (A) and bypass off/output reg (B).
module tb_mor1kx_multiport_dpram_sclk;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [3:0]    wbe;
  logic [AW-1:0] waddr;
  logic [DW-1:0] din;
  logic [NR-1:0] re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] dout_a, dout_b;
  logic [NR-1:0]    dvalid_a, dvalid_b;
  logic             busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mor1kx_multiport_dpram_sclk #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR),
    .ENABLE_BYPASS(1), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout_a), .dvalid(dvalid_a), .init_busy(busy_a)
  );

  mor1kx_multiport_dpram_sclk #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR),
    .ENABLE_BYPASS(0), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout_b), .dvalid(dvalid_b), .init_busy(busy_b)
  );

  typedef struct {
    logic          we;
    logic [3:0]    wbe;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic [NR-1:0] re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] ea0;  // bypass on, latency 1
    logic [DW-1:0] ea1;
    logic [DW-1:0] eb0;  // read-first, latency 2
    logic [DW-1:0] eb1;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  logic [DW-1:0] mm [1<<AW];
  logic [DW-1:0] ea_d [NR];
  logic [NR-1:0] ea_v;
  logic [DW-1:0] eb1_d [NR];
  logic [NR-1:0] eb1_v;
  logic [DW-1:0] eb2_d [NR];
  logic [NR-1:0] eb2_v;

  task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wbe = '0; waddr = '0; din = '0; re = '0; raddr = '0;
  endtask

  // Counts init_busy-high cycles of each instance while hammering the inputs.
  task automatic run_init(input string tag);
    int na, nb, n;
    na = 0; nb = 0; n = 0;
    while ((busy_a || busy_b) && n < 64) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      we = 1'($urandom); wbe = 4'($urandom); waddr = AW'($urandom);
      din = $urandom; re = NR'($urandom); raddr = (NR*AW)'($urandom);
      cyc();
      n++;
      chk({tag, "_init_dvalid_a"}, (NR*DW)'(dvalid_a), '0);
      chk({tag, "_init_dvalid_b"}, (NR*DW)'(dvalid_b), '0);
    end
    idle();
    chk({tag, "_init_len_a"}, (NR*DW)'(na), (NR*DW)'(16));
    chk({tag, "_init_len_b"}, (NR*DW)'(nb), (NR*DW)'(16));
  endtask

  initial begin
    logic [NR*DW-1:0] pa, pb;
    logic [DW-1:0]    old_w, byp_w;
    logic [AW-1:0]    ra [NR];

    vt[0]  = '{1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 3'b000, 4'd0, 4'd0, 32'h0,        32'h0,        32'h0,        32'h0};
    vt[1]  = '{1'b0, 4'h0, 4'd0, 32'h0,        3'b011, 4'd3, 4'd3, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD};
    vt[2]  = '{1'b1, 4'hF, 4'd5, 32'h11223344, 3'b000, 4'd0, 4'd0, 32'h0,        32'h0,        32'h0,        32'h0};
    vt[3]  = '{1'b1, 4'h5, 4'd5, 32'hFFFFFFFF, 3'b011, 4'd5, 4'd5, 32'h11FF33FF, 32'h11FF33FF, 32'h11223344, 32'h11223344};
    vt[4]  = '{1'b0, 4'h0, 4'd0, 32'h0,        3'b001, 4'd5, 4'd0, 32'h11FF33FF, 32'h0,        32'h11FF33FF, 32'h0};
    vt[5]  = '{1'b1, 4'hF, 4'd7, 32'h12345678, 3'b000, 4'd0, 4'd0, 32'h0,        32'h0,        32'h0,        32'h0};
    vt[6]  = '{1'b1, 4'h0, 4'd7, 32'hFFFFFFFF, 3'b011, 4'd7, 4'd7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vt[7]  = '{1'b0, 4'h0, 4'd0, 32'h0,        3'b011, 4'd7, 4'd3, 32'h12345678, 32'hAABBCCDD, 32'h12345678, 32'hAABBCCDD};
    vt[8]  = '{1'b1, 4'h8, 4'd3, 32'h00000000, 3'b011, 4'd0, 4'd3, 32'h0,        32'h00BBCCDD, 32'h0,        32'hAABBCCDD};
    vt[9]  = '{1'b0, 4'h0, 4'd0, 32'h0,        3'b000, 4'd0, 4'd0, 32'h0,        32'h0,        32'h0,        32'h0};
    vt[10] = '{1'b0, 4'h0, 4'd0, 32'h0,        3'b011, 4'd3, 4'd3, 32'h00BBCCDD, 32'h00BBCCDD, 32'h00BBCCDD, 32'h00BBCCDD};

    rst_n = 1'b0;
    idle();
    repeat (3) cyc();
    chk("rst_busy_a", (NR*DW)'(busy_a), (NR*DW)'(1));
    chk("rst_busy_b", (NR*DW)'(busy_b), (NR*DW)'(1));
    chk("rst_dvalid_a", (NR*DW)'(dvalid_a), '0);
    chk("rst_dout_a", dout_a, '0);
    chk("rst_dout_b", dout_b, '0);

    rst_n = 1'b1;
    run_init("first");

    for (int a = 0; a < 16; a++) begin
      re = 3'b011;
      raddr = {AW'(0), AW'(a), AW'(a)};
      cyc();
      chk("clr_dvalid_a", (NR*DW)'(dvalid_a), (NR*DW)'(3'b011));
      chk("clr_dout_a", dout_a, '0);
      chk("clr_dvalid_b", (NR*DW)'(dvalid_b), (a > 0) ? (NR*DW)'(3'b011) : '0);
      chk("clr_dout_b", dout_b, '0);
    end
    idle();
    cyc();
    chk("clr_tail_dvalid_a", (NR*DW)'(dvalid_a), '0);
    chk("clr_tail_dvalid_b", (NR*DW)'(dvalid_b), (NR*DW)'(3'b011));

    for (int k = 0; k <= NV; k++) begin
      if (k < NV) begin
        we = vt[k].we; wbe = vt[k].wbe; waddr = vt[k].waddr; din = vt[k].din;
        re = vt[k].re; raddr = {AW'(0), vt[k].ra1, vt[k].ra0};
      end else begin
        idle();
      end
      cyc();
      if (k < NV) begin
        chk($sformatf("vec%0d_dvalid_a", k), (NR*DW)'(dvalid_a), (NR*DW)'(vt[k].re));
        if (vt[k].re[0]) chk($sformatf("vec%0d_dout0_a", k), (NR*DW)'(dout_a[31:0]), (NR*DW)'(vt[k].ea0));
        if (vt[k].re[1]) chk($sformatf("vec%0d_dout1_a", k), (NR*DW)'(dout_a[63:32]), (NR*DW)'(vt[k].ea1));
      end
      if (k > 0) begin
        chk($sformatf("vec%0d_dvalid_b", k-1), (NR*DW)'(dvalid_b), (NR*DW)'(vt[k-1].re));
        if (vt[k-1].re[0]) chk($sformatf("vec%0d_dout0_b", k-1), (NR*DW)'(dout_b[31:0]), (NR*DW)'(vt[k-1].eb0));
        if (vt[k-1].re[1]) chk($sformatf("vec%0d_dout1_b", k-1), (NR*DW)'(dout_b[63:32]), (NR*DW)'(vt[k-1].eb1));
      end
    end
    cyc();
    chk("hold_dout_a", (NR*DW)'(dout_a[63:0]), (NR*DW)'({32'h00BBCCDD, 32'h00BBCCDD}));
    chk("hold_dout_b", (NR*DW)'(dout_b[63:0]), (NR*DW)'({32'h00BBCCDD, 32'h00BBCCDD}));
    chk("hold_dvalid_b", (NR*DW)'(dvalid_b), '0);

    // Reset in the middle of the clear sweep.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    chk("midclr_busy_before", (NR*DW)'(busy_a), (NR*DW)'(1));
    rst_n = 1'b0;
    #1;
    chk("midclr_busy_a", (NR*DW)'(busy_a), (NR*DW)'(1));
    chk("midclr_busy_b", (NR*DW)'(busy_b), (NR*DW)'(1));
    cyc();
    rst_n = 1'b1;
    run_init("midclr");

    // Reset with reads in flight.
    we = 1'b1; wbe = 4'hF; waddr = 4'd2; din = 32'hDEADBEEF;
    cyc();
    idle();
    re = 3'b111; raddr = {4'd2, 4'd2, 4'd2};
    cyc();
    idle();
    chk("inflight_dvalid_a_pre", (NR*DW)'(dvalid_a), (NR*DW)'(3'b111));
    chk("inflight_dout_a_pre", dout_a, {3{32'hDEADBEEF}});
    rst_n = 1'b0;
    #1;
    chk("inflight_dvalid_a", (NR*DW)'(dvalid_a), '0);
    chk("inflight_dout_a", dout_a, '0);
    chk("inflight_busy_a", (NR*DW)'(busy_a), (NR*DW)'(1));
    cyc();
    chk("inflight_dvalid_b", (NR*DW)'(dvalid_b), '0);
    chk("inflight_dout_b", dout_b, '0);
    rst_n = 1'b1;
    run_init("inflight");

    // Random traffic against a byte-level reference model, starting from a cleared array.
    for (int i = 0; i < (1 << AW); i++) mm[i] = '0;
    for (int i = 0; i < NR; i++) begin
      ea_d[i] = '0; eb1_d[i] = '0; eb2_d[i] = '0;
    end
    ea_v = '0; eb1_v = '0; eb2_v = '0;

    for (int c = 0; c < 10000; c++) begin
      we    = 1'($urandom);
      wbe   = 4'($urandom);
      waddr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      din   = $urandom;
      re    = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        ra[i] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        raddr[i*AW +: AW] = ra[i];
      end

      for (int i = 0; i < NR; i++) begin
        old_w = mm[ra[i]];
        byp_w = old_w;
        if (we && waddr == ra[i])
          for (int b = 0; b < 4; b++) if (wbe[b]) byp_w[8*b +: 8] = din[8*b +: 8];
        ea_v[i] = re[i];
        if (re[i]) ea_d[i] = byp_w;
        eb2_v[i] = eb1_v[i];
        if (eb1_v[i]) eb2_d[i] = eb1_d[i];
        eb1_v[i] = re[i];
        if (re[i]) eb1_d[i] = old_w;
      end
      if (we)
        for (int b = 0; b < 4; b++) if (wbe[b]) mm[waddr][8*b +: 8] = din[8*b +: 8];

      cyc();
      for (int i = 0; i < NR; i++) begin
        pa[i*DW +: DW] = ea_d[i];
        pb[i*DW +: DW] = eb2_d[i];
      end
      chk("rnd_dout_a", dout_a, pa);
      chk("rnd_dvalid_a", (NR*DW)'(dvalid_a), (NR*DW)'(ea_v));
      chk("rnd_dout_b", dout_b, pb);
      chk("rnd_dvalid_b", (NR*DW)'(dvalid_b), (NR*DW)'(eb2_v));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
